// File: rtl/clock_monitor.sv
// Period / lock / stuck monitor for a slow clock sampled in the system clock domain.
// Optional high-time measurement is built when CLOCK_MONITOR_DUTY_EN is defined.
module clock_monitor #(
  parameter int unsigned EXPECT_PERIOD = 72000000,
  parameter int unsigned TOLERANCE     = 720,
  parameter int unsigned TIMEOUT       = 144000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             in_range,
  output logic             locked,
  output logic             stuck
);

  localparam int unsigned EXT_W = CNT_W + 1;
  localparam logic [EXT_W-1:0] RANGE_LO = (EXPECT_PERIOD > TOLERANCE) ?
                                          EXT_W'(EXPECT_PERIOD - TOLERANCE) : '0;
  localparam logic [EXT_W-1:0] RANGE_HI = EXT_W'(EXPECT_PERIOD) + EXT_W'(TOLERANCE);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

  state_t           state, state_n;
  logic             sync1, sync_q, hist;
  logic             rise_det;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] period_n;
  logic             meas_valid_n, in_range_n, locked_n, stuck_n;
  logic             streak, streak_n;
  logic             cnt_ok;

  assign rise_det = sync_q & ~hist;
  assign cnt_ok   = ({1'b0, cnt} >= RANGE_LO) && ({1'b0, cnt} <= RANGE_HI);

  // Next-state and datapath updates; an edge in MEASURE wins over the timeout.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    period_n     = period_out;
    meas_valid_n = 1'b0;
    in_range_n   = in_range;
    locked_n     = locked;
    stuck_n      = stuck;
    streak_n     = streak;
    if (!enable) begin
      state_n  = IDLE;
      cnt_n    = '0;
      locked_n = 1'b0;
      stuck_n  = 1'b0;
      streak_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n    = '0;
          locked_n = 1'b0;
          state_n  = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (rise_det) begin
            cnt_n   = CNT_W'(1);
            stuck_n = 1'b0;
            state_n = MEASURE;
          end else if (cnt == TIMEOUT_V) begin
            stuck_n  = 1'b1;
            locked_n = 1'b0;
            streak_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        MEASURE: begin
          if (rise_det) begin
            period_n     = cnt;
            in_range_n   = cnt_ok;
            meas_valid_n = 1'b1;
            locked_n     = cnt_ok & streak;
            streak_n     = cnt_ok;
            stuck_n      = 1'b0;
            cnt_n        = CNT_W'(1);
          end else if (cnt == TIMEOUT_V) begin
            stuck_n  = 1'b1;
            locked_n = 1'b0;
            streak_n = 1'b0;
            state_n  = WAIT_EDGE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync_q     <= 1'b0;
      hist       <= 1'b0;
      cnt        <= '0;
      period_out <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
      streak     <= 1'b0;
    end else begin
      state      <= state_n;
      sync1      <= sig_in;
      sync_q     <= sync1;
      hist       <= sync_q;
      cnt        <= cnt_n;
      period_out <= period_n;
      meas_valid <= meas_valid_n;
      in_range   <= in_range_n;
      locked     <= locked_n;
      stuck      <= stuck_n;
      streak     <= streak_n;
    end
  end

`ifdef CLOCK_MONITOR_DUTY_EN
  logic             fall_det;
  logic [CNT_W-1:0] hcnt;
  logic             hrun;

  assign fall_det = ~sync_q & hist;

  // High-time counter: starts on a rising edge, freezes on the falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt     <= '0;
      hrun     <= 1'b0;
      high_out <= '0;
    end else if (!enable || state == IDLE) begin
      hrun <= 1'b0;
    end else if (rise_det) begin
      hcnt <= CNT_W'(1);
      hrun <= 1'b1;
      if (state == MEASURE) high_out <= hcnt;
    end else if (fall_det) begin
      hrun <= 1'b0;
    end else if (hrun && hcnt != '1) begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end
`else
  assign high_out = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: each driven rising edge queues the measurement it should produce.
module tb_clock_monitor;

  localparam int unsigned CNT_W         = 32;
  localparam int unsigned EXPECT_PERIOD = 20;
  localparam int unsigned TOLERANCE     = 2;
  localparam int unsigned TIMEOUT       = 40;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             in_range;
  logic             locked;
  logic             stuck;

  clock_monitor #(
    .EXPECT_PERIOD(EXPECT_PERIOD),
    .TOLERANCE    (TOLERANCE),
    .TIMEOUT      (TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .in_range  (in_range),
    .locked    (locked),
    .stuck     (stuck)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
    logic        inr;
    logic        lck;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state, kept in terms of driven sig_in edges.
  int   last_rise = 0;
  int   last_high = 0;
  bit   have_edge = 1'b0;
  bit   streak_m  = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rise();
    int   p;
    bit   inr;
    exp_t e;
    if (have_edge) begin
      p = cyc - last_rise;
      if (p > int'(TIMEOUT)) begin
        streak_m = 1'b0;
      end else begin
        inr      = (p >= int'(EXPECT_PERIOD - TOLERANCE)) && (p <= int'(EXPECT_PERIOD + TOLERANCE));
        e.period = 32'(p);
`ifdef CLOCK_MONITOR_DUTY_EN
        e.high   = 32'(last_high);
`else
        e.high   = 32'd0;
`endif
        e.inr    = inr;
        e.lck    = inr && streak_m;
        streak_m = inr;
        exp_q.push_back(e);
      end
    end
    have_edge = 1'b1;
    last_rise = cyc;
    sig_in    = 1'b1;
  endtask

  task automatic fall();
    last_high = cyc - last_rise;
    sig_in    = 1'b0;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      rise();
      tick(hi);
      fall();
      tick(lo);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, period_out, 32'd0);
    check({tag, "_high"}, high_out, 32'd0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_in_range"}, 32'(in_range), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_stuck"}, 32'(stuck), 32'd0);
  endtask

  // Output monitor: every meas_valid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && meas_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_meas_valid", 32'(meas_valid), 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("period_out", period_out, e_mon.period);
        check("high_out", high_out, e_mon.high);
        check("in_range", 32'(in_range), 32'(e_mon.inr));
        check("locked", 32'(locked), 32'(e_mon.lck));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    tick(3);
    check_zero("reset");
    reset  = 1'b0;
    enable = 1'b1;
    tick(2);

    // Nominal 10/10 clock: lock after the second measurement.
    wave(10, 10, 5);
    check("locked_nominal", 32'(locked), 32'd1);

    // Period 25 breaks lock; relock on 20.
    wave(10, 15, 1);
    wave(10, 10, 3);
    check("stuck_after_change", 32'(stuck), 32'd0);

    // 8 high / 12 low.
    wave(8, 12, 3);

    // Period exactly TIMEOUT is measured, TIMEOUT+1 times out.
    wave(20, 20, 1);
    rise();
    tick(6);
    check("stuck_at_timeout_edge", 32'(stuck), 32'd0);
    tick(14);
    fall();
    tick(21);
    rise();
    tick(2);
    check("stuck_past_timeout", 32'(stuck), 32'd1);
    tick(3);
    check("stuck_cleared_by_edge", 32'(stuck), 32'd0);
    tick(5);
    fall();
    tick(10);
    wave(10, 10, 3);

    // Hold sig_in low after lock.
    rise();
    tick(10);
    fall();
    tick(25);
    check("locked_before_stuck", 32'(locked), 32'd1);
    check("stuck_before_timeout", 32'(stuck), 32'd0);
    tick(13);
    check("stuck_held_low", 32'(stuck), 32'd1);
    check("locked_cleared_stuck", 32'(locked), 32'd0);
    tick(10);
    rise();
    tick(5);
    check("stuck_cleared", 32'(stuck), 32'd0);
    tick(5);
    fall();
    tick(10);
    wave(10, 10, 3);

    // Enable dropped mid-period: results held, measurement restarts.
    rise();
    tick(10);
    fall();
    tick(3);
    enable    = 1'b0;
    have_edge = 1'b0;
    streak_m  = 1'b0;
    tick(2);
    check("dis_meas_valid", 32'(meas_valid), 32'd0);
    check("dis_period_held", period_out, 32'd20);
    check("dis_in_range_held", 32'(in_range), 32'd1);
    check("dis_locked", 32'(locked), 32'd0);
    check("dis_stuck", 32'(stuck), 32'd0);
    tick(2);
    check("dis_period_held2", period_out, 32'd20);
    enable = 1'b1;
    tick(3);
    wave(10, 10, 3);

    // Reset mid-MEASURE discards everything.
    rise();
    tick(10);
    fall();
    tick(4);
    reset = 1'b1;
    tick(1);
    reset     = 1'b0;
    have_edge = 1'b0;
    streak_m  = 1'b0;
    check_zero("midreset");
    tick(5);
    wave(10, 10, 3);
    wave(8, 12, 2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("pending_measurements", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
